// File: rtl/piece_merge.sv
// rtl/piece_merge.sv - writes a locked tetromino into the playfield, then flags full rows (option: COLLISION_CHECK_EN)
module piece_merge #(
    parameter int ROWS = 22,
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [ROWS-1:0][COLS-1:0][CW-1:0] i_c_grid,
    input  logic [3:0][3:0]                 i_piece_mask,
    input  logic [4:0]                      i_piece_row,
    input  logic [3:0]                      i_piece_col,
    input  logic [CW-1:0]                   i_piece_color,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0] o_n_grid,
    output logic [ROWS-1:0]                 o_full_rows,
    output logic [2:0]                      o_lines,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_clear_en
`ifdef COLLISION_CHECK_EN
    ,
    output logic                            o_collision,
    output logic                            o_oob
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_SCAN, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [ROWS-1:0][COLS-1:0][CW-1:0] r_grid;
    logic [3:0][3:0]                 r_mask;
    logic [4:0]                      r_row;
    logic [3:0]                      r_col;
    logic [CW-1:0]                   r_color;
    logic [1:0]                      r_idx;
    logic [ROWS-1:0]                 r_full;
    logic [2:0]                      r_lines;

    logic                            w_accept;
    logic [5:0]                      w_row_sel;
    logic [3:0][5:0]                 w_cols;
    logic [COLS-1:0]                 w_col_hit;
    logic [ROWS-1:0]                 w_full;
    logic [4:0]                      w_cnt;
    logic [2:0]                      w_lines;

    // a colourless piece would be indistinguishable from empty cells, so it never starts a merge
    assign w_accept = (r_state == S_IDLE) && i_start && (i_piece_color != '0);

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state: one mask row per MERGE cycle, then a single SCAN and DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MERGE;
            S_MERGE: if (r_idx == 2'd3) w_next = S_SCAN;
            S_SCAN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // decode the current box row into a target grid row and a set of in-grid columns
    always_comb begin
        w_row_sel = {1'b0, r_row} + {4'b0000, r_idx};
        w_col_hit = '0;
        for (int j = 0; j < 4; j++) begin
            w_cols[j] = {2'b00, r_col} + 6'(j);
            if (r_mask[r_idx][j] && (w_row_sel < 6'(ROWS))) begin
                for (int cc = 0; cc < COLS; cc++) begin
                    if (w_cols[j] == 6'(cc)) w_col_hit[cc] = 1'b1;
                end
            end
        end
    end

    // full-row detection on the merged grid; count clamps at 7 to fit the 3-bit output
    always_comb begin
        w_full = '0;
        w_cnt  = '0;
        for (int rr = 0; rr < ROWS; rr++) begin
            w_full[rr] = 1'b1;
            for (int cc = 0; cc < COLS; cc++) begin
                if (r_grid[rr][cc] == '0) w_full[rr] = 1'b0;
            end
            w_cnt = w_cnt + {4'b0000, w_full[rr]};
        end
        w_lines = (w_cnt > 5'd7) ? 3'd7 : w_cnt[2:0];
    end

    // grid datapath: latch on start, overwrite occupied cells during MERGE, capture scan result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grid  <= '0;
            r_mask  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_color <= '0;
            r_idx   <= '0;
            r_full  <= '0;
            r_lines <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grid  <= i_c_grid;
                        r_mask  <= i_piece_mask;
                        r_row   <= i_piece_row;
                        r_col   <= i_piece_col;
                        r_color <= i_piece_color;
                        r_idx   <= '0;
                    end
                end
                S_MERGE: begin
                    for (int rr = 0; rr < ROWS; rr++) begin
                        for (int cc = 0; cc < COLS; cc++) begin
                            if ((w_row_sel == 6'(rr)) && w_col_hit[cc]) r_grid[rr][cc] <= r_color;
                        end
                    end
                    r_idx <= r_idx + 2'd1;
                end
                S_SCAN: begin
                    r_full  <= w_full;
                    r_lines <= w_lines;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_CHECK_EN
    logic r_collision;
    logic r_oob;
    logic w_coll;
    logic w_drop;

    // a set mask bit is dropped when its row or column falls outside the grid;
    // a collision is a write onto a cell that already held a colour
    always_comb begin
        w_drop = 1'b0;
        w_coll = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (r_mask[r_idx][j] && ((w_row_sel >= 6'(ROWS)) || (w_cols[j] >= 6'(COLS)))) w_drop = 1'b1;
        end
        for (int rr = 0; rr < ROWS; rr++) begin
            for (int cc = 0; cc < COLS; cc++) begin
                if ((w_row_sel == 6'(rr)) && w_col_hit[cc] && (r_grid[rr][cc] != '0)) w_coll = 1'b1;
            end
        end
    end

    // sticky flags, cleared only when a new piece is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
        end else if (w_accept) begin
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
        end else if (r_state == S_MERGE) begin
            r_collision <= r_collision | w_coll;
            r_oob       <= r_oob | w_drop;
        end
    end

    assign o_collision = r_collision;
    assign o_oob       = r_oob;
`endif

    assign o_n_grid    = r_grid;
    assign o_full_rows = r_full;
    assign o_lines     = r_lines;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_clear_en  = (r_state == S_DONE);

endmodule

// File: tb/tb_piece_merge.sv
// tb/tb_piece_merge.sv - vector table plus scoreboard bench for piece_merge
`timescale 1ns/1ps
module tb_piece_merge;
    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int CW   = 3;

    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_t;
    typedef logic [3:0][3:0] mask_t;
    typedef struct {
        grid_t           grid;
        mask_t           mask;
        logic [4:0]      row;
        logic [3:0]      col;
        logic [CW-1:0]   color;
        logic [ROWS-1:0] exp_full;
        logic [2:0]      exp_lines;
        logic            exp_coll;
        logic            exp_oob;
    } vec_t;
    typedef struct {
        grid_t           grid;
        logic [ROWS-1:0] full;
        logic [2:0]      lines;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    grid_t           c_grid = '0;
    mask_t           mask = '0;
    logic [4:0]      prow = '0;
    logic [3:0]      pcol = '0;
    logic [CW-1:0]   color = '0;
    grid_t           n_grid;
    logic [ROWS-1:0] full_rows;
    logic [2:0]      lines;
    logic            busy, done, clear_en;
`ifdef COLLISION_CHECK_EN
    logic            collision, oob;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    exp_t sb[$];
    exp_t e_mon;
    vec_t vecs[7];

    piece_merge #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_c_grid(c_grid),
        .i_piece_mask(mask), .i_piece_row(prow), .i_piece_col(pcol), .i_piece_color(color),
        .o_n_grid(n_grid), .o_full_rows(full_rows), .o_lines(lines),
        .o_busy(busy), .o_done(done), .o_clear_en(clear_en)
`ifdef COLLISION_CHECK_EN
        , .o_collision(collision), .o_oob(oob)
`endif
    );

    always #20 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic int grid_diff(input grid_t a, input grid_t b);
        int d = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (a[r][c] !== b[r][c]) d++;
        return d;
    endfunction

    function automatic grid_t merge_model(input grid_t g, input mask_t m, input logic [4:0] row,
                                          input logic [3:0] col, input logic [CW-1:0] cl);
        grid_t n = g;
        int r, c;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                r = int'(row) + i;
                c = int'(col) + j;
                if (m[i][j] && r < ROWS && c < COLS) n[r][c] = cl;
            end
        return n;
    endfunction

    // scoreboard: each done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check(clear_en === 1'b1, "clear_en_eq_done", 64'(clear_en), 64'd1);
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_done", 64'd1, 64'd0);
            end else begin
                e_mon = sb.pop_front();
                check(grid_diff(n_grid, e_mon.grid) == 0, "n_grid_cells_diff",
                      64'(grid_diff(n_grid, e_mon.grid)), 64'd0);
                check(full_rows === e_mon.full, "full_rows", 64'(full_rows), 64'(e_mon.full));
                check(lines === e_mon.lines, "lines", 64'(lines), 64'(e_mon.lines));
            end
        end
    end

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int k;
        @(negedge clk);
        c_grid = v.grid; mask = v.mask; prow = v.row; pcol = v.col; color = v.color;
        start = 1'b1;
        e.grid = merge_model(v.grid, v.mask, v.row, v.col, v.color);
        e.full = v.exp_full;
        e.lines = v.exp_lines;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check(busy === 1'b1, {tag, "_busy_after_start"}, 64'(busy), 64'd1);
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(done === 1'b1, {tag, "_done_timeout"}, 64'(done), 64'd1);
        check(k - 1 == 5, {tag, "_latency_edges"}, 64'(k - 1), 64'd5);
`ifdef COLLISION_CHECK_EN
        check(collision === v.exp_coll, {tag, "_collision"}, 64'(collision), 64'(v.exp_coll));
        check(oob === v.exp_oob, {tag, "_oob"}, 64'(oob), 64'(v.exp_oob));
`endif
        @(negedge clk);
        check(done === 1'b0 && busy === 1'b0, {tag, "_done_one_cycle"}, 64'({done, busy}), 64'd0);
    endtask

    initial begin : watchdog
        #4000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        grid_t g;
        int busy_err, d0;

        // table: T1 O-piece at bottom, T2 single line, pre-full rows with empty mask,
        // overlap, column overflow, four-line clear, empty mask on empty grid
        for (int i = 0; i < 7; i++) begin
            vecs[i].grid = '0; vecs[i].mask = '0; vecs[i].row = '0; vecs[i].col = '0;
            vecs[i].color = 3'd1; vecs[i].exp_full = '0; vecs[i].exp_lines = '0;
            vecs[i].exp_coll = 1'b0; vecs[i].exp_oob = 1'b0;
        end
        vecs[0].mask[1][1] = 1'b1; vecs[0].mask[1][2] = 1'b1;
        vecs[0].mask[2][1] = 1'b1; vecs[0].mask[2][2] = 1'b1;
        vecs[0].row = 5'd20; vecs[0].col = 4'd4; vecs[0].color = 3'd3; vecs[0].exp_oob = 1'b1;

        g = '0;
        for (int c = 0; c < 6; c++) g[21][c] = 3'd1;
        g[21][9] = 3'd1;
        vecs[1].grid = g; vecs[1].mask[0] = 4'b0111; vecs[1].row = 5'd21; vecs[1].col = 4'd6;
        vecs[1].color = 3'd2; vecs[1].exp_full = 22'(1) << 21; vecs[1].exp_lines = 3'd1;

        g = '0;
        for (int c = 0; c < COLS; c++) begin g[10][c] = 3'd4; g[15][c] = 3'd4; end
        g[3][2] = 3'd5;
        vecs[2].grid = g; vecs[2].color = 3'd5;
        vecs[2].exp_full = (22'(1) << 10) | (22'(1) << 15); vecs[2].exp_lines = 3'd2;

        g = '0; g[5][5] = 3'd7;
        vecs[3].grid = g; vecs[3].mask[0] = 4'b0010; vecs[3].mask[1] = 4'b0111;
        vecs[3].row = 5'd4; vecs[3].col = 4'd4; vecs[3].color = 3'd2; vecs[3].exp_coll = 1'b1;

        vecs[4].mask[0] = 4'b1001; vecs[4].row = 5'd3; vecs[4].col = 4'd8;
        vecs[4].color = 3'd6; vecs[4].exp_oob = 1'b1;

        g = '0;
        for (int r = 18; r < 22; r++) for (int c = 1; c < COLS; c++) g[r][c] = 3'd1;
        vecs[5].grid = g; vecs[5].mask = 16'h1111; vecs[5].row = 5'd18; vecs[5].col = 4'd0;
        vecs[5].color = 3'd6; vecs[5].exp_full = 22'h3C0000; vecs[5].exp_lines = 3'd4;

        vecs[6].color = 3'd4;

        // reset state
        repeat (3) @(negedge clk);
        check(n_grid === '0, "rst_n_grid", 64'(grid_diff(n_grid, '0)), 64'd0);
        check(full_rows === '0, "rst_full_rows", 64'(full_rows), 64'd0);
        check(lines === 3'd0, "rst_lines", 64'(lines), 64'd0);
        check({busy, done, clear_en} === 3'b000, "rst_flags", 64'({busy, done, clear_en}), 64'd0);
`ifdef COLLISION_CHECK_EN
        check({collision, oob} === 2'b00, "rst_coll_oob", 64'({collision, oob}), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                check(n_grid[21][5] === 3'd3 && n_grid[21][6] === 3'd3, "t1_cells_21_5_6",
                      64'({n_grid[21][5], n_grid[21][6]}), 64'({3'd3, 3'd3}));
                check(n_grid[20][5] === 3'd0, "t1_cell_20_5", 64'(n_grid[20][5]), 64'd0);
            end
            if (i == 1)
                check(n_grid[21][8] === 3'd2 && full_rows === 22'h200000, "t2_row21",
                      64'(full_rows), 64'h200000);
            if (i == 3)
                check(n_grid[5][5] === 3'd2, "t5_overwrite_5_5", 64'(n_grid[5][5]), 64'd2);
            if (i == 4)
                check(n_grid[3][8] === 3'd6 && n_grid[3][9] === 3'd0, "t5_col_edge",
                      64'({n_grid[3][8], n_grid[3][9]}), 64'({3'd6, 3'd0}));
            if (i == 6)
                check(grid_diff(n_grid, '0) == 0 && lines === 3'd0, "t6_empty_unchanged",
                      64'(lines), 64'd0);
        end

        // T3: start held high for 20 edges accepts at edges 0, 7 and 14 only
        d0 = n_done;
        busy_err = 0;
        @(negedge clk);
        c_grid = vecs[1].grid; mask = vecs[1].mask; prow = vecs[1].row; pcol = vecs[1].col;
        color = vecs[1].color; start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            sb.push_back('{merge_model(vecs[1].grid, vecs[1].mask, vecs[1].row, vecs[1].col,
                                       vecs[1].color), vecs[1].exp_full, vecs[1].exp_lines});
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy !== (((k - 1) % 7) != 6)) busy_err++;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check(busy_err == 0, "t3_busy_pattern", 64'(busy_err), 64'd0);
        check(n_done - d0 == 3, "t3_done_count", 64'(n_done - d0), 64'd3);

        // colour 0 never starts
        busy_err = 0;
        d0 = n_done;
        color = 3'd0; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_err++;
        end
        start = 1'b0;
        check(busy_err == 0 && n_done == d0, "t3_color0_ignored", 64'(busy_err), 64'd0);

        // T4: reset while merging box row 2 clears everything and suppresses done
        run_op(vecs[5], "t4_prep");
        d0 = n_done;
        @(negedge clk);
        c_grid = vecs[5].grid; mask = vecs[5].mask; prow = vecs[5].row; pcol = vecs[5].col;
        color = vecs[5].color; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check(grid_diff(n_grid, '0) == 0, "t4_rst_grid", 64'(grid_diff(n_grid, '0)), 64'd0);
        check(lines === 3'd0 && full_rows === '0, "t4_rst_lines_full", 64'(lines), 64'd0);
        check({busy, done, clear_en} === 3'b000, "t4_rst_flags", 64'({busy, done, clear_en}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check(n_done == d0, "t4_no_done", 64'(n_done - d0), 64'd0);
        check(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
